// File: rtl/pad_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pad_input_conditioner
//  Description : Per-pad synchroniser + programmable debouncer producing a
//                clean level and one-cycle rise/fall pulses. Optional sticky
//                edge-event flags and irq under `PAD_IN_STICKY_EVENT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_input_conditioner #(
    parameter int NUM_PADS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_PADS-1:0]   pad_i,
    input  logic [NUM_PADS-1:0]   en_i,
    input  logic [DEBOUNCE_W-1:0] debounce_cycles_i,
    output logic [NUM_PADS-1:0]   level_o,
    output logic [NUM_PADS-1:0]   rise_o,
    output logic [NUM_PADS-1:0]   fall_o
`ifdef PAD_IN_STICKY_EVENT_EN
    ,
    input  logic [NUM_PADS-1:0]   event_clr_i,
    output logic [NUM_PADS-1:0]   event_o,
    output logic                  irq_o
`endif
);

    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] sync;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pad_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        logic [DEBOUNCE_W-1:0] cnt_q;
        logic                  level_q;
        logic                  rise_q;
        logic                  fall_q;

        // The >= compare keeps cnt_q bounded by N, so it can never wrap and
        // lowering N below an in-flight count commits on the next cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (!en_i[i] || (sync[i] == level_q)) begin
                    cnt_q <= '0;
                end else if (cnt_q >= debounce_cycles_i) begin
                    cnt_q   <= '0;
                    level_q <= sync[i];
                    rise_q  <= sync[i];
                    fall_q  <= ~sync[i];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign level_o[i] = level_q;
        assign rise_o[i]  = rise_q;
        assign fall_o[i]  = fall_q;
    end

`ifdef PAD_IN_STICKY_EVENT_EN
    logic [NUM_PADS-1:0] event_q;

    // Set has priority over a coincident clear so no edge is ever lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_q <= '0;
        end else begin
            event_q <= (event_q & ~event_clr_i) | rise_o | fall_o;
        end
    end

    assign event_o = event_q;
    assign irq_o   = |event_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pad_input_conditioner.sv
`default_nettype none
// Scoreboard bench for pad_input_conditioner: expected pulses are queued by
// the stimulus and matched by an independent monitor on every output pulse.
module tb_pad_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pad;
    logic [3:0] en;
    logic [7:0] nthr;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
`ifdef PAD_IN_STICKY_EVENT_EN
    logic [3:0] clr;
    logic [3:0] evt;
    logic       irq;
`endif

    pad_input_conditioner dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pad_i             (pad),
        .en_i              (en),
        .debounce_cycles_i (nthr),
        .level_o           (level),
        .rise_o            (rise),
        .fall_o            (fall)
`ifdef PAD_IN_STICKY_EVENT_EN
        ,
        .event_clr_i       (clr),
        .event_o           (evt),
        .irq_o             (irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] l;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // Monitor: every cycle carrying a pulse must match the head of the queue.
    always @(negedge clk) begin
        if ((rise | fall) != 4'h0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d rise=%h fall=%h level=%h, required no pulse",
                         cyc, rise, fall, level);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || rise != e.r || fall != e.f || level != e.l) begin
                    errors++;
                    $display("FAIL pulse cyc=%0d rise=%h fall=%h level=%h, required cyc=%0d rise=%h fall=%h level=%h",
                             cyc, rise, fall, level, e.cyc, e.r, e.f, e.l);
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
        exp_t x;
        x.cyc = c; x.r = r; x.f = f; x.l = l;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    int c;
    int d;

    initial begin
        rst_n = 1'b0; pad = 4'hF; en = 4'hF; nthr = 8'd3;
`ifdef PAD_IN_STICKY_EVENT_EN
        clr = 4'h0;
`endif
        tick(3);
        chk("reset_level", 32'(level), 32'h0);
        chk("reset_rise",  32'(rise),  32'h0);
        chk("reset_fall",  32'(fall),  32'h0);

        // Release with all pads high: rise on all pads 6 cycles later.
        c = cyc; rst_n = 1'b1; push(c + 6, 4'hF, 4'h0, 4'hF);
        tick(10);
        c = cyc; pad = 4'h0; push(c + 6, 4'h0, 4'hF, 4'h0);
        tick(10);

        // Glitch rejection, N=4: 4 high cycles rejected, 5 accepted.
        nthr = 8'd4;
        c = cyc; pad[0] = 1'b1; tick(4); pad[0] = 1'b0;
        tick(12);
        chk("glitch_level", 32'(level), 32'h0);
        c = cyc; pad[0] = 1'b1; push(c + 7, 4'h1, 4'h0, 4'h1);
        tick(5); pad[0] = 1'b0; push(c + 12, 4'h0, 4'h1, 4'h0);
        tick(12);

        // N=0: pad[1] toggled every 3 cycles, 3-cycle latency.
        nthr = 8'd0;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            pad[1] = ~pad[1];
            if (pad[1]) push(c + 3*k + 3, 4'h2, 4'h0, 4'h2);
            else        push(c + 3*k + 3, 4'h0, 4'h2, 4'h0);
            tick(3);
        end
        tick(5);

        // Enable gating, N=10: drop en[2] at count 7, re-enable later.
        nthr = 8'd10;
        c = cyc; pad[2] = 1'b1; tick(9); en[2] = 1'b0;
        tick(5);
        chk("gate_frozen_a", 32'(level[2]), 32'h0);
        tick(6);
        chk("gate_frozen_b", 32'(level[2]), 32'h0);
        d = cyc; en[2] = 1'b1; push(d + 11, 4'h4, 4'h0, 4'h4);
        tick(10);
        chk("gate_before_11", 32'(level[2]), 32'h0);
        tick(5);
        c = cyc; pad[2] = 1'b0; push(c + 13, 4'h0, 4'h4, 4'h0);
        tick(16);

        // Async reset mid-count with N=200.
        nthr = 8'd0;
        c = cyc; pad[0] = 1'b1; push(c + 3, 4'h1, 4'h0, 4'h1);
        tick(5);
        nthr = 8'd200;
        c = cyc; pad[3] = 1'b1; tick(102);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_level", 32'(level), 32'h0);
        tick(3);
        d = cyc; rst_n = 1'b1; push(d + 203, 4'h9, 4'h0, 4'h9);
        tick(202);
        chk("post_reset_hold", 32'(level), 32'h0);
        tick(8);

`ifdef PAD_IN_STICKY_EVENT_EN
        chk("evt_after_rise", 32'(evt), 32'h9);
        chk("irq_after_rise", 32'(irq), 32'h1);
        clr = 4'h1; tick(1); clr = 4'h0;
        chk("evt_clr0", 32'(evt), 32'h8);
        chk("irq_still", 32'(irq), 32'h1);
        nthr = 8'd0;
        c = cyc; pad[3] = 1'b0; push(c + 3, 4'h0, 4'h8, 4'h1);
        tick(3); clr = 4'h8; tick(1); clr = 4'h0;
        chk("evt_set_wins", 32'(evt), 32'h8);
        tick(2); clr = 4'h8; tick(1); clr = 4'h0;
        chk("evt_lone_clr", 32'(evt), 32'h0);
        chk("irq_cleared", 32'(irq), 32'h0);
`endif

        tick(5);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
